// File: rtl/vc_arb_pkg.sv
// rtl/vc_arb_pkg.sv - shared types and helpers for the valid/credit link arbiter
//
// Purpose: arbiter state encoding and an index-width helper that stays legal
// when a requester count of one is used (plain $clog2(1) would give zero bits).
// Ports: none (package).

package vc_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: choose the first set bit of req at or above ptr, wrapping modulo N_REQ.
// Ports:
//   req    in   N_REQ  request mask
//   ptr    in   IW     priority pointer (index searched first)
//   grant  out  N_REQ  one-hot grant, zero when no request
//   idx    out  IW     binary index of the granted requester
//   found  out  1      any request present

module rr_pick
  import vc_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]              req,
  input  logic [idx_width(N_REQ)-1:0]   ptr,
  output logic [N_REQ-1:0]              grant,
  output logic [idx_width(N_REQ)-1:0]   idx,
  output logic                          found
);

  localparam int IW = idx_width(N_REQ);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr) + i) % N_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/vc_credit_arbiter.sv
// rtl/vc_credit_arbiter.sv - credit-based N-way packet arbiter onto one valid/credit link
//
// Purpose: round-robin arbitration among valid/ready requesters, packet locking
// so multi-beat packets are never interleaved, and sender-side credit tracking.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_data_i     N_REQ*DATA_WIDTH  requester payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid_i    N_REQ             per-requester valid
//   req_last_i     N_REQ             per-requester last beat of packet
//   req_ready_o    N_REQ             per-requester ready, at most one bit set
//   m_data_o       DATA_WIDTH        registered link payload
//   m_valid_o      1                 registered link valid, one cycle per beat
//   m_src_o        IW                registered source id of the beat
//   m_credit_i     1                 credit return pulse
//   busy_o         1                 a packet is locked
//   credit_cnt_o   CW                current credit count
//   credit_err_o   1                 sticky: credit returned while already full

module vc_credit_arbiter
  import vc_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ*DATA_WIDTH-1:0]     req_data_i,
  input  logic [N_REQ-1:0]                req_valid_i,
  input  logic [N_REQ-1:0]                req_last_i,
  output logic [N_REQ-1:0]                req_ready_o,
  output logic [DATA_WIDTH-1:0]           m_data_o,
  output logic                            m_valid_o,
  output logic [idx_width(N_REQ)-1:0]     m_src_o,
  input  logic                            m_credit_i,
  output logic                            busy_o,
  output logic [$clog2(CREDIT_NUM):0]     credit_cnt_o,
  output logic                            credit_err_o
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = $clog2(CREDIT_NUM) + 1;

  arb_state_e      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   lock_id;
  logic [CW-1:0]   credit_cnt;
  logic            credit_err;

  logic [N_REQ-1:0]      pick_grant;
  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic                  can_send;
  logic [IW-1:0]         sel_id;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [IW-1:0]         next_ptr;
  logic                  fire;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Only the registered count gates sending, so a credit arriving this cycle
  // cannot be spent until the next one; this keeps m_credit_i off every output path.
  assign can_send = (credit_cnt != '0);

  always_comb begin
    req_ready_o = '0;
    if (can_send) begin
      if (state == ARB_LOCKED) begin
        req_ready_o[lock_id] = req_valid_i[lock_id];
      end else if (pick_found) begin
        req_ready_o = pick_grant;
      end
    end
  end

  assign sel_id   = (state == ARB_LOCKED) ? lock_id : pick_idx;
  assign sel_last = req_last_i[sel_id];
  assign sel_data = req_data_i[sel_id*DATA_WIDTH +: DATA_WIDTH];
  assign next_ptr = (sel_id == IW'(N_REQ - 1)) ? '0 : sel_id + 1'b1;
  assign fire     = |(req_valid_i & req_ready_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      lock_id    <= '0;
      credit_cnt <= '0;
      credit_err <= 1'b0;
      m_valid_o  <= 1'b0;
      m_data_o   <= '0;
      m_src_o    <= '0;
    end else begin
      m_valid_o <= fire;
      if (fire) begin
        m_data_o <= sel_data;
        m_src_o  <= sel_id;
        if (sel_last) begin
          state  <= ARB_IDLE;
          rr_ptr <= next_ptr;
        end else begin
          state   <= ARB_LOCKED;
          lock_id <= sel_id;
        end
      end

      // A return and a spend in the same cycle cancel out.
      if (m_credit_i && !fire) begin
        if (credit_cnt == CW'(CREDIT_NUM)) begin
          credit_err <= 1'b1;
        end else begin
          credit_cnt <= credit_cnt + 1'b1;
        end
      end else if (!m_credit_i && fire) begin
        credit_cnt <= credit_cnt - 1'b1;
      end
    end
  end

  assign busy_o       = (state == ARB_LOCKED);
  assign credit_cnt_o = credit_cnt;
  assign credit_err_o = credit_err;

endmodule

// File: tb/tb_vc_credit_arbiter.sv
// tb/tb_vc_credit_arbiter.sv - scoreboard bench for vc_credit_arbiter

module tb_vc_credit_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CN = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_last_i;
  logic [N-1:0]    req_ready_o;
  logic [DW-1:0]   m_data_o;
  logic            m_valid_o;
  logic [1:0]      m_src_o;
  logic            m_credit_i;
  logic            busy_o;
  logic [1:0]      credit_cnt_o;
  logic            credit_err_o;

  vc_credit_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .CREDIT_NUM(CN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_data_i   (req_data_i),
    .req_valid_i  (req_valid_i),
    .req_last_i   (req_last_i),
    .req_ready_o  (req_ready_o),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_src_o      (m_src_o),
    .m_credit_i   (m_credit_i),
    .busy_o       (busy_o),
    .credit_cnt_o (credit_cnt_o),
    .credit_err_o (credit_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    int            src;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    src_log[$];
  int    busy_log[$];

  int tests  = 0;
  int failed = 0;

  // Reference model state: credits held, next search start, locked requester (-1 = none).
  int m_cred;
  int m_ptr;
  int m_lock;
  bit m_err;

  int cnt_obs;
  int err_obs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N*DW-1:0] rd();
    return (N*DW)'($urandom);
  endfunction

  function automatic logic cred_ok();
    return m_cred < CN;
  endfunction

  task automatic model_reset();
    m_cred = 0;
    m_ptr  = 0;
    m_lock = -1;
    m_err  = 1'b0;
  endtask

  task automatic monitor();
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_valid_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(m_src_o), 32'hdead);
          end else begin
            b = exp_q.pop_front();
            chk("beat_cycle", cyc, b.cyc);
            chk("beat_src", 32'(m_src_o), b.src);
            chk("beat_data", 32'(m_data_o), 32'(b.data));
            src_log.push_back(int'(m_src_o));
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          b = exp_q.pop_front();
          chk("missing_beat", 32'(m_valid_o), 32'd1);
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic [N*DW-1:0] d, input logic c);
    int            win;
    logic [N-1:0]  er;
    beat_t         b;
    @(negedge clk);
    chk("credit_cnt", 32'(credit_cnt_o), m_cred);
    chk("busy", 32'(busy_o), 32'(m_lock >= 0));
    chk("credit_err", 32'(credit_err_o), 32'(m_err));
    cnt_obs = int'(credit_cnt_o);
    err_obs = int'(credit_err_o);
    busy_log.push_back(int'(busy_o));
    req_valid_i = v;
    req_last_i  = l;
    req_data_i  = d;
    m_credit_i  = c;
    #1;
    win = -1;
    if (m_cred > 0) begin
      if (m_lock >= 0) begin
        if (v[m_lock]) win = m_lock;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (win < 0 && v[j]) win = j;
        end
      end
    end
    er = '0;
    if (win >= 0) er[win] = 1'b1;
    chk("req_ready", 32'(req_ready_o), 32'(er));
    if (win >= 0) begin
      b.cyc  = cyc + 1;
      b.src  = win;
      b.data = d[win*DW +: DW];
      exp_q.push_back(b);
      if (l[win]) begin
        m_lock = -1;
        m_ptr  = (win + 1) % N;
      end else begin
        m_lock = win;
      end
    end
    if (c && win < 0) begin
      if (m_cred == CN) m_err = 1'b1;
      else m_cred++;
    end else if (!c && win >= 0) begin
      m_cred--;
    end
  endtask

  // Call just after a negedge; asserts reset between edges and checks the
  // outputs fall without waiting for a clock.
  task automatic do_reset();
    #2;
    req_valid_i = '0;
    req_last_i  = '0;
    m_credit_i  = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid_o), 0);
    chk("rst_m_data", 32'(m_data_o), 0);
    chk("rst_m_src", 32'(m_src_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_credit_cnt", 32'(credit_cnt_o), 0);
    chk("rst_credit_err", 32'(credit_err_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  int rr_exp[6] = '{0, 1, 3, 0, 1, 3};
  int lk_src[4] = '{2, 2, 2, 0};
  int lk_bsy[4] = '{0, 1, 1, 0};

  initial begin
    rst_n       = 1'b0;
    req_data_i  = '0;
    req_valid_i = '0;
    req_last_i  = '0;
    m_credit_i  = 1'b0;
    model_reset();
    fork
      monitor();
    join_none

    @(negedge clk);
    do_reset();

    // Credits from reset
    step(4'b0001, 4'b0001, rd(), 1'b0);
    step(4'b0001, 4'b0001, rd(), 1'b0);
    chk("ready_no_credit", 32'(req_ready_o), 0);
    step(4'b0000, 4'b0000, rd(), 1'b1);
    step(4'b0000, 4'b0000, rd(), 1'b1);
    step(4'b0001, 4'b0001, rd(), 1'b0);
    chk("cnt_after_credits", cnt_obs, 2);
    chk("ready_req0", 32'(req_ready_o), 32'b0001);
    step(4'b0001, 4'b0001, rd(), 1'b0);
    step(4'b0001, 4'b0001, rd(), 1'b0);
    chk("cnt_drained", cnt_obs, 0);
    chk("ready_dropped", 32'(req_ready_o), 0);
    step(4'b0000, 4'b0000, rd(), 1'b0);

    // Round-robin over 1011
    @(negedge clk);
    do_reset();
    src_log.delete();
    for (int i = 0; i < 7; i++) step(4'b1011, 4'b1111, rd(), cred_ok());
    step(4'b0000, 4'b0000, rd(), 1'b0);
    chk("rr_count", src_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < src_log.size()) chk($sformatf("rr_src%0d", i), src_log[i], rr_exp[i]);
    end

    // Packet lock: requester 1 first moves the pointer to 2
    step(4'b0010, 4'b0010, rd(), cred_ok());
    step(4'b0000, 4'b0000, rd(), cred_ok());
    src_log.delete();
    busy_log.delete();
    step(4'b0101, 4'b0001, rd(), cred_ok());
    step(4'b0101, 4'b0001, rd(), cred_ok());
    step(4'b0101, 4'b0101, rd(), cred_ok());
    step(4'b0001, 4'b0001, rd(), cred_ok());
    step(4'b0000, 4'b0000, rd(), 1'b0);
    chk("lock_count", src_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < src_log.size()) chk($sformatf("lock_src%0d", i), src_log[i], lk_src[i]);
      chk($sformatf("lock_busy%0d", i), busy_log[i], lk_bsy[i]);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom), N'($urandom), rd(), cred_ok() && ($urandom_range(0, 3) != 0));
    end
    step(4'b0000, 4'b0000, rd(), 1'b0);

    // Credit boundaries
    @(negedge clk);
    do_reset();
    step(4'b0000, 4'b0000, rd(), 1'b1);
    step(4'b0001, 4'b0001, rd(), 1'b1);
    step(4'b0000, 4'b0000, rd(), 1'b0);
    chk("cnt_credit_and_send", cnt_obs, 1);
    step(4'b0000, 4'b0000, rd(), 1'b1);
    step(4'b0000, 4'b0000, rd(), 1'b1);
    step(4'b0000, 4'b0000, rd(), 1'b0);
    chk("cnt_saturated", cnt_obs, 2);
    chk("err_set", err_obs, 1);
    step(4'b0000, 4'b0000, rd(), 1'b0);
    chk("err_sticky", err_obs, 1);

    // Reset in the middle of a locked packet
    @(negedge clk);
    do_reset();
    step(4'b0000, 4'b0000, rd(), 1'b1);
    step(4'b0000, 4'b0000, rd(), 1'b1);
    step(4'b0100, 4'b0100, rd(), 1'b0);
    step(4'b0010, 4'b0000, rd(), 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy_o), 1);
    chk("pre_rst_valid", 32'(m_valid_o), 1);
    chk("pre_rst_src", 32'(m_src_o), 1);
    do_reset();
    src_log.delete();
    step(4'b0000, 4'b0000, rd(), 1'b1);
    step(4'b1100, 4'b1100, rd(), 1'b0);
    step(4'b0000, 4'b0000, rd(), 1'b0);
    chk("post_rst_count", src_log.size(), 1);
    if (src_log.size() > 0) chk("post_rst_src", src_log[0], 2);

    step(4'b0000, 4'b0000, rd(), 1'b0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vc_credit_arbiter.md
Name: vc_credit_arbiter

Overview:
- Shares one valid/credit link between N_REQ valid/ready requesters.
- Its master side drives the slave side of the team's valid/credit-to-valid/ready converter; its requester side faces local producers.
- Owns the sender-side credit count, round-robin grant selection, and packet locking, so a multi-beat packet from one requester is never interleaved with another.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, payload width per beat.
- CREDIT_NUM, 2, credits the downstream receiver returns after reset; equals the receiver FIFO depth.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; one clock, asynchronous assert, active-low.
- req_data_i  input  N_REQ*DATA_WIDTH  requester payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid_i  input  N_REQ  per-requester valid.
- req_last_i  input  N_REQ  per-requester last-beat-of-packet flag.
- req_ready_o  output  N_REQ  per-requester ready; at most one bit set.
- m_data_o  output  DATA_WIDTH  registered link payload.
- m_valid_o  output  1  registered link valid; one-cycle pulse per beat.
- m_src_o  output  $clog2(N_REQ)  registered source id of the current beat.
- m_credit_i  input  1  credit return pulse; one credit per cycle high.
- busy_o  output  1  high while a packet is locked.
- credit_cnt_o  output  $clog2(CREDIT_NUM)+1  current credit count.
- credit_err_o  output  1  sticky error: a credit was returned while the count was already CREDIT_NUM.

Behaviour:
- Reset values: m_data_o=0, m_valid_o=0, m_src_o=0, busy_o=0, credit_cnt_o=0, credit_err_o=0, state=ARB_IDLE, rr pointer=0.
- Credits start at 0; the receiver hands out CREDIT_NUM pulses after reset.
- Credit count, evaluated each cycle:
  - +1 when m_credit_i=1.
  - -1 when a beat is accepted (fire = |(req_valid_i & req_ready_o)).
  - Both in the same cycle: count unchanged.
  - Increment at CREDIT_NUM: count saturates and credit_err_o sets; it clears only on reset.
- can_send = (credit_cnt != 0). Uses the registered count only; an incoming credit pulse cannot be spent in the same cycle.
- ARB_IDLE:
  - If can_send and any req_valid_i is set, round-robin pick the first valid requester at or above the pointer, wrapping modulo N_REQ.
  - req_ready_o[winner]=1 combinationally; all other bits 0.
  - On fire with req_last_i[winner]=0: go to ARB_LOCKED with lock_id=winner.
  - On fire with req_last_i[winner]=1: stay in ARB_IDLE; pointer=(winner+1) mod N_REQ.
- ARB_LOCKED:
  - req_ready_o[lock_id] = can_send & req_valid_i[lock_id]; all other requesters are blocked even if valid.
  - On fire with req_last_i[lock_id]=1: go to ARB_IDLE; pointer=(lock_id+1) mod N_REQ.
  - Valid dropping mid-packet: stay locked and wait; no timeout.
- Output register:
  - On fire: next cycle m_valid_o=1, m_data_o=winner's data, m_src_o=winner.
  - Otherwise m_valid_o=0; m_data_o and m_src_o hold.
  - Latency is 1 cycle from accept to link; throughput is 1 beat/cycle while credits last.
- busy_o=1 exactly when state=ARB_LOCKED.
- No credits: all req_ready_o=0; state and pointer hold.
- No combinational path from m_credit_i to any output.
- Reset mid-packet: everything returns to reset values immediately; the partial packet is dropped (the downstream side is reset with the same rst_n).

Decomposition:
- Package vc_arb_pkg holds:
  - typedef enum arb_state_e {ARB_IDLE, ARB_LOCKED};
  - function clog2-safe width helper for N_REQ=1 edge use.
- Sub-module rr_pick: purely combinational; inputs req mask and pointer; outputs one-hot grant and binary index.
- Counters, FSM and output register stay in vc_credit_arbiter.

Test Plan (N_REQ=4, CREDIT_NUM=2):
- Credits from reset: hold req_valid_i=4'b0001 with no credits -> req_ready_o=0. Apply 2 credit pulses -> credit_cnt_o=2; requester 0 then accepts 2 single-beat packets on consecutive cycles, credit_cnt_o returns to 0, and req_ready_o drops.
- Round-robin: req_valid_i=4'b1011 with all last=1, credit returned every cycle -> m_src_o sequence 0,1,3,0,1,3.
- Packet lock: requester 2 sends 3 beats (last on beat 3) while requester 0 is valid throughout -> m_src_o=2,2,2 then 0; busy_o high from the cycle after beat 1 is accepted until the cycle after beat 3 is accepted.
- Simultaneous credit and send at count 1 -> count stays 1. Credit pulse at count 2 -> count stays 2 and credit_err_o=1 (sticky).
- Reset asserted in ARB_LOCKED mid-packet -> outputs go to reset values immediately without a clock edge; after release, a new packet is arbitrated from pointer 0.
